stall_request_issuer: RTL
=========================

Name: stall_request_issuer

Overview:
Initiator side of the core's stall interface. Accepts one long-latency accelerator command at a time from the core pipeline and computes the stall length. Emits a one-cycle stall request (pulse plus 13-bit count) to the core stall generator, launches the accelerator, and waits for completion under a watchdog. It then performs one status-read cycle and returns a response to the core with a ready/valid handshake.

Parameters:
DATA_W, 32, width of accelerator status word and response status
LEN_W, 12, width of command length field (elements)
OVH_SHORT, 4, fixed overhead cycles for short ops (op[3]=0)
OVH_LONG, 16, fixed overhead cycles for long ops (op[3]=1)
WD_EXTRA, 8, watchdog slack cycles beyond the nominal stall window

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, synchronous, active-low
i_cmd_valid  input  1  core command valid
o_cmd_ready  output  1  block can accept a command
i_cmd_op  input  4  command opcode; bit 3 selects long op
i_cmd_len  input  LEN_W  element count
o_stall_gen  output  1  one-cycle stall request pulse to the stall generator
o_stall_count  output  13  stall count qualified by o_stall_gen
o_acc_start  output  1  one-cycle accelerator launch pulse
o_acc_op  output  4  latched opcode, stable from ISSUE until IDLE
o_acc_len  output  LEN_W  latched length, stable from ISSUE until IDLE
i_acc_done  input  1  accelerator completion pulse
o_status_rd  output  1  one-cycle status read strobe
i_status_data  input  DATA_W  status word, valid in the o_status_rd cycle
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  core accepts response
o_rsp_status  output  DATA_W  captured status (0 on timeout)
o_rsp_timeout  output  1  response caused by watchdog expiry

Behaviour:
- Reset (i_rst_n low at a clock edge): state=IDLE. All outputs are 0 except o_cmd_ready=1. Latched op, len, count, status and watchdog are cleared. Reset mid-operation aborts without a response. The downstream stall counter is not affected.
- Stall count, computed from the latched command in a 14-bit intermediate:
  - op[3]=0: len + OVH_SHORT.
  - op[3]=1: (len<<1) + OVH_LONG.
  - The result saturates to 13'h1FFF when above 8191.
- IDLE: o_cmd_ready=1.
  - On i_cmd_valid & o_cmd_ready, latch op and len and register the count, then go to ISSUE.
  - o_cmd_ready=0 in every other state; i_cmd_valid is ignored there.
- ISSUE (exactly 1 cycle):
  - o_stall_gen=1, o_stall_count=count_q, o_acc_start=1.
  - Load watchdog (15-bit) = 2*(count_q+1) + WD_EXTRA. Go to WAIT.
  - i_acc_done in this cycle is ignored; the accelerator guarantees latency of at least 1.
- WAIT: the watchdog decrements every cycle.
  - If i_acc_done=1, go to STATUS.
  - Else if watchdog==0, go to RESP with timeout=1 and status=0.
  - If done and watchdog==0 occur in the same cycle, done wins.
- STATUS (1 cycle): o_status_rd=1. Capture i_status_data in the same cycle. Go to RESP with timeout=0.
- RESP: o_rsp_valid=1, with o_rsp_status and o_rsp_timeout held stable until i_rsp_ready. On the handshake, go to IDLE.
  - New command acceptance starts the cycle after the handshake; there is no same-cycle bypass.
- o_stall_count is 0 whenever o_stall_gen=0.
- Latency for a normal command:
  - Command accept at cycle t, ISSUE at t+1, WAIT from t+2.
  - Done at cycle d gives STATUS at d+1 and o_rsp_valid from d+2.

Decomposition:
- Package stall_req_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, STATUS, RESP);
  - STALL_CNT_W=13 and WD_W=15;
  - the overhead constants;
  - a saturating calc_stall_count function shared with future stall initiators.
- One sub-module, stall_watchdog: load, decrement and zero-flag counter of width WD_W.

Test Plan:
- op=0x0, len=10, done after 20 WAIT cycles, rsp_ready=1 → one stall_gen pulse with count=14, acc_start in the same cycle, status_rd 1 cycle after done, rsp_valid with status=i_status_data and timeout=0.
- op=0x8, len=4095 → o_stall_count=8191 (saturated); op=0x8, len=5 → count=26.
- op=0x0, len=10, done never asserted → watchdog=38, rsp_valid 40 cycles after the ISSUE cycle with timeout=1 and status=0; no status_rd.
- Done coincident with watchdog==0 → STATUS taken, timeout=0. Done asserted in the ISSUE cycle only → ignored, ends in timeout.
- rsp_ready held low 5 cycles with cmd_valid high throughout → response stable, cmd_ready=0. New command accepted the cycle after rsp_ready rises.
- i_rst_n low for 1 cycle during WAIT → next cycle IDLE, all outputs 0 except cmd_ready=1; no response; late i_acc_done ignored.

Source files
------------

// File: rtl/stall_req_pkg.sv
// Shared types, widths and the stall-length calculation for stall-interface initiators.
package stall_req_pkg;

   localparam int unsigned STALL_CNT_W     = 13;
   localparam int unsigned WD_W            = 15;
   localparam int unsigned STALL_OVH_SHORT = 4;
   localparam int unsigned STALL_OVH_LONG  = 16;

   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StStatus,
      StResp
   } state_e;

   // Short ops cost len + ovh_short; long ops cost 2*len + ovh_long; clamped to 13 bits.
   function automatic logic [STALL_CNT_W-1:0] calc_stall_count(
      input logic                   long_op,
      input logic [STALL_CNT_W-2:0] len,
      input logic [STALL_CNT_W:0]   ovh_short,
      input logic [STALL_CNT_W:0]   ovh_long
   );
      logic [STALL_CNT_W:0] sum;
      if (long_op) begin
         sum = {1'b0, len, 1'b0} + ovh_long;
      end else begin
         sum = {2'b00, len} + ovh_short;
      end
      if (sum > {1'b0, STALL_CNT_MAX}) begin
         return STALL_CNT_MAX;
      end
      return sum[STALL_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Loadable down-counter that stops at zero and flags when it gets there.
module stall_watchdog
   import stall_req_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [WD_W-1:0] load_val,
   input  logic            dec,
   output logic            zero
);

   logic [WD_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && !zero) begin
         cnt_q <= cnt_q - WD_W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/stall_request_issuer.sv
// Issues a stall request for one accelerator command, waits for completion under a
// watchdog, reads status once and hands a response back to the core.
module stall_request_issuer
   import stall_req_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 12,
   parameter int unsigned OVH_SHORT = STALL_OVH_SHORT,
   parameter int unsigned OVH_LONG  = STALL_OVH_LONG,
   parameter int unsigned WD_EXTRA  = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [3:0]             i_cmd_op,
   input  logic [LEN_W-1:0]       i_cmd_len,
   output logic                   o_stall_gen,
   output logic [STALL_CNT_W-1:0] o_stall_count,
   output logic                   o_acc_start,
   output logic [3:0]             o_acc_op,
   output logic [LEN_W-1:0]       o_acc_len,
   input  logic                   i_acc_done,
   output logic                   o_status_rd,
   input  logic [DATA_W-1:0]      i_status_data,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [DATA_W-1:0]      o_rsp_status,
   output logic                   o_rsp_timeout
);

   state_e                 state_q, state_d;
   logic [3:0]             op_q;
   logic [LEN_W-1:0]       len_q;
   logic [STALL_CNT_W-1:0] count_q;
   logic [DATA_W-1:0]      status_q;
   logic                   timeout_q;
   logic                   accept;
   logic                   wd_zero;
   logic [WD_W-1:0]        wd_load_val;

   assign accept      = (state_q == StIdle) && i_cmd_valid;
   // 2*(count+1) + slack, i.e. twice the nominal stall window plus margin
   assign wd_load_val = WD_W'({count_q, 1'b0}) + WD_W'(2 + WD_EXTRA);

   stall_watchdog u_watchdog (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .load     (state_q == StIssue),
      .load_val (wd_load_val),
      .dec      (state_q == StWait),
      .zero     (wd_zero)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (i_cmd_valid) state_d = StIssue;
         StIssue:  state_d = StWait;
         StWait: begin
            // completion takes priority over a simultaneous expiry
            if (i_acc_done) begin
               state_d = StStatus;
            end else if (wd_zero) begin
               state_d = StResp;
            end
         end
         StStatus: state_d = StResp;
         StResp:   if (i_rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         op_q      <= '0;
         len_q     <= '0;
         count_q   <= '0;
         status_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= i_cmd_op;
            len_q   <= i_cmd_len;
            count_q <= calc_stall_count(i_cmd_op[3], (STALL_CNT_W-1)'(i_cmd_len),
                                        (STALL_CNT_W+1)'(OVH_SHORT),
                                        (STALL_CNT_W+1)'(OVH_LONG));
         end
         if (state_q == StWait && !i_acc_done && wd_zero) begin
            status_q  <= '0;
            timeout_q <= 1'b1;
         end
         if (state_q == StStatus) begin
            status_q  <= i_status_data;
            timeout_q <= 1'b0;
         end
      end
   end

   assign o_cmd_ready   = (state_q == StIdle);
   assign o_stall_gen   = (state_q == StIssue);
   assign o_stall_count = o_stall_gen ? count_q : '0;
   assign o_acc_start   = (state_q == StIssue);
   assign o_acc_op      = op_q;
   assign o_acc_len     = len_q;
   assign o_status_rd   = (state_q == StStatus);
   assign o_rsp_valid   = (state_q == StResp);
   assign o_rsp_status  = o_rsp_valid ? status_q : '0;
   assign o_rsp_timeout = o_rsp_valid && timeout_q;

endmodule
